alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning operand and result width in bits (legal values 8..64, even).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  operation request.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port a  input  N  first operand.
REQ-007 The block SHALL have port b  input  N  second operand.
REQ-008 The block SHALL have port ALUControl  input  4  operation code.
REQ-009 The block SHALL have port result  output  N  registered result.
REQ-010 The block SHALL have port zero  output  1  result == 0.
REQ-011 The block SHALL have port out_valid  output  1  result and zero are valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-015 a, b and ALUControl SHALL be captured at acceptance; later input changes SHALL NOT affect the operation.
REQ-016 Single-cycle ops SHALL go IDLE->DONE at acceptance, giving out_valid=1 on the next cycle: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 PASSB (b), 1100 NOR.
REQ-017 Iterative ops SHALL go IDLE->BUSY: 1000 MUL (low N bits of a*b, two's-complement wrap), 1001 UDIV (unsigned a/b), 1010 UREM (unsigned a%b).
REQ-018 MUL SHALL use one shift-add step per cycle; UDIV/UREM SHALL use one restoring-division step per cycle.
REQ-019 BUSY SHALL last exactly N cycles, tracked by a counter from 0 to N-1; on the edge after count N-1 the FSM SHALL enter DONE.
REQ-020 out_valid SHALL therefore assert N+1 cycles after acceptance for iterative ops.
REQ-021 For b=0, UDIV SHALL return all ones and UREM SHALL return a, each still taking N BUSY cycles.
REQ-022 Undefined ALUControl codes SHALL complete as single-cycle ops with result=0 and zero=1.
REQ-023 ADD, SUB and MUL SHALL wrap modulo 2^N; no overflow or carry flag is produced.
REQ-024 zero SHALL be registered together with result and always equal (result==0).
REQ-025 out_valid SHALL be 1 only in DONE; result and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 DONE->IDLE SHALL occur on an edge with out_ready=1; in_ready becomes 1 on the following cycle, so there is no same-cycle re-accept.
REQ-027 in_valid in BUSY or DONE SHALL be ignored (not queued).

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, counter=0, result=0, zero=1, out_valid=0 and in_ready=1 on the next cycle.
REQ-029 Reset SHALL take priority over acceptance and completion, including mid-BUSY, where the partial operation is discarded.

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode constants/enum (AND, OR, ADD, SUB, PASSB, NOR, MUL, UDIV, UREM) and the state enum.
REQ-031 The iterative datapath SHALL be a sub-module alu_iter (shift-add/restoring-divide engine with start, step counter and done), parametrised by N.
REQ-032 The single-cycle ops SHALL be combinational logic feeding the result register in the top level.

Verification
REQ-033 N=64, a=-1, b=-2, ADD accepted -> next cycle out_valid=1, result=-3, zero=0; PASSB -> result=-2; NOR -> result=0, zero=1.
REQ-034 N=64, a=7, b=-3, MUL -> in_ready=0 for 64 BUSY cycles, out_valid at cycle 65, result=-21.
REQ-035 N=64, a=100, b=7: UDIV -> 14; UREM -> 2; a=5, b=0: UDIV -> all ones; UREM -> 5, each after 65 cycles.
REQ-036 Hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> result, zero and out_valid stay unchanged, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-037 Assert reset at BUSY cycle 20 of a MUL -> next cycle IDLE, out_valid=0, result=0, zero=1; a following ADD 1+1 -> result=2.
REQ-038 N=8, a=16, b=16, MUL -> out_valid after 9 cycles, result=0, zero=1 (wrap).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and iterative-engine mode definitions for alu_muldiv.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_NOR   = 4'b1100,
        OP_MUL   = 4'b1000,
        OP_UDIV  = 4'b1001,
        OP_UREM  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_REM} iter_e;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Multi-cycle engine: one shift-add (MUL) or restoring-divide (UDIV/UREM) step per cycle, N steps.
module alu_iter import alu_pkg::*; #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  iter_e        op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] res
);
    localparam int CW = $clog2(N);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    iter_e         r_op;
    // MUL: acc/multiplicand/multiplier. DIV: remainder/dividend-quotient/divisor.
    logic [N-1:0]  r_acc, r_x, r_y;

    logic [N-1:0]  w_acc_mul, w_rem, w_quo;
    logic [N:0]    w_rsh;
    logic          w_ge;

    assign w_acc_mul = r_acc + (r_y[0] ? r_x : '0);
    assign w_rsh     = {r_acc, r_x[N-1]};
    assign w_ge      = (w_rsh >= {1'b0, r_y});
    // When w_ge the true difference is below the divisor, so N-bit wrap is exact.
    assign w_rem     = w_ge ? (w_rsh[N-1:0] - r_y) : w_rsh[N-1:0];
    assign w_quo     = {r_x[N-2:0], w_ge};

    assign done = r_run && (r_cnt == CW'(N-1));

    always_comb begin
        res = w_rem;
        case (r_op)
            IT_MUL:  res = w_acc_mul;
            IT_DIV:  res = w_quo;
            default: res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_op  <= IT_MUL;
            r_acc <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_op  <= op;
            r_acc <= '0;
            r_x   <= a;
            r_y   <= b;
        end else if (r_run) begin
            r_cnt <= done ? '0 : r_cnt + CW'(1);
            if (done)
                r_run <= 1'b0;
            if (r_op == IT_MUL) begin
                r_acc <= w_acc_mul;
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_acc <= w_rem;
                r_x   <= w_quo;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith ops and iterative MUL/UDIV/UREM behind a valid/ready handshake.
module alu_muldiv import alu_pkg::*; #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);
    state_e       r_state;
    logic [N-1:0] r_result;
    logic         r_zero, r_in_ready, r_out_valid;

    logic [N-1:0] w_single, w_iter_res;
    logic         w_start, w_iter_done;
    iter_e        w_iop;

    always_comb begin
        w_single = '0;
        case (ALUControl)
            OP_AND:   w_single = a & b;
            OP_OR:    w_single = a | b;
            OP_ADD:   w_single = a + b;
            OP_SUB:   w_single = a - b;
            OP_PASSB: w_single = b;
            OP_NOR:   w_single = ~(a | b);
            default:  w_single = '0;
        endcase
    end

    always_comb begin
        w_iop = IT_REM;
        case (ALUControl)
            OP_MUL:  w_iop = IT_MUL;
            OP_UDIV: w_iop = IT_DIV;
            default: w_iop = IT_REM;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && in_valid && is_iter(ALUControl);

    alu_iter #(.N(N)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .op    (w_iop),
        .a     (a),
        .b     (b),
        .done  (w_iter_done),
        .res   (w_iter_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_in_ready <= 1'b0;
                    if (is_iter(ALUControl)) begin
                        r_state <= ST_BUSY;
                    end else begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_single;
                        r_zero      <= (w_single == '0);
                    end
                end
                ST_BUSY: if (w_iter_done) begin
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                    r_result    <= w_iter_res;
                    r_zero      <= (w_iter_res == '0);
                end
                ST_DONE: if (out_ready) begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: cycle-level reference model on the N=64 instance plus directed N=8 checks.
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, zero, out_valid, out_ready;
    logic [63:0] a, b, result;
    logic [3:0]  ALUControl;
    logic        in_valid8, in_ready8, zero8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  ALUControl8;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv #(.N(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUControl(ALUControl), .result(result), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    alu_muldiv #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ALUControl(ALUControl8), .result(result8), .zero(zero8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return y;
            4'b1100: return ~(x | y);
            4'b1000: return x * y;
            4'b1001: return (y == 0) ? '1 : x / y;
            4'b1010: return (y == 0) ? x : x % y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit is_it(input logic [3:0] op);
        return op == 4'b1000 || op == 4'b1001 || op == 4'b1010;
    endfunction

    // Reference: 0 idle, 1 busy (m_cnt cycles left), 2 done; m_out is the visible result.
    int          m_st, m_cnt;
    logic [63:0] m_pend, m_out;

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_cnt = 0; m_out = 64'd0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_pend = ref_op(ALUControl, a, b);
                    if (is_it(ALUControl)) begin
                        m_st = 1; m_cnt = 64;
                    end else begin
                        m_st = 2; m_out = m_pend;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_st = 2; m_out = m_pend; end
                end
                default: if (out_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_in_ready", {63'd0, in_ready}, {63'd0, m_st == 0});
            chk("mdl_out_valid", {63'd0, out_valid}, {63'd0, m_st == 2});
            chk("mdl_result", result, m_out);
            chk("mdl_zero", {63'd0, zero}, {63'd0, m_out == 0});
        end
    end

    // Accept one op, scramble inputs, measure latency, optionally hold DONE, then drain.
    task automatic run64(input string nm, input logic [3:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int lat, input int hold);
        int cyc;
        @(negedge clk);
        ALUControl = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; ALUControl = 4'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (cyc == 1) chk({nm, "_busy_rdy"}, {63'd0, in_ready}, 64'd0);
            @(negedge clk); cyc++;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk(nm, result, exp);
        chk({nm, "_zero"}, {63'd0, zero}, {63'd0, exp == 0});
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid; a = {$urandom, $urandom}; b = {$urandom, $urandom};
            @(negedge clk);
            chk({nm, "_hold_res"}, result, exp);
            chk({nm, "_hold_vld"}, {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_back_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic run8(input string nm, input logic [3:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] exp, input int lat);
        int cyc;
        @(negedge clk);
        ALUControl8 = op; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1;
        while (!out_valid8 && cyc < 50) begin @(negedge clk); cyc++; end
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk(nm, {56'd0, result8}, {56'd0, exp});
        chk({nm, "_zero"}, {63'd0, zero8}, {63'd0, exp == 0});
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ALUControl = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; ALUControl8 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", {result[62:0], zero, in_ready, out_valid}, 64'b110);
        chk_en = 1'b1;

        run64("add_m1_m2", 4'b0010, '1, -64'sd2, -64'sd3, 1, 0);
        run64("passb", 4'b0111, '1, -64'sd2, -64'sd2, 1, 0);
        run64("nor", 4'b1100, '1, -64'sd2, 64'd0, 1, 0);
        run64("undef", 4'b0011, 64'd5, 64'd9, 64'd0, 1, 0);
        run64("mul_7_m3", 4'b1000, 64'd7, -64'sd3, -64'sd21, 65, 0);
        run64("udiv_100_7", 4'b1001, 64'd100, 64'd7, 64'd14, 65, 0);
        run64("urem_100_7", 4'b1010, 64'd100, 64'd7, 64'd2, 65, 0);
        run64("udiv_5_0", 4'b1001, 64'd5, 64'd0, '1, 65, 0);
        run64("urem_5_0", 4'b1010, 64'd5, 64'd0, 64'd5, 65, 0);
        run64("sub_hold", 4'b0110, 64'd3, 64'd10, -64'sd7, 1, 10);

        // Reset in the middle of a MUL discards it.
        @(negedge clk);
        ALUControl = 4'b1000; a = 64'd7; b = -64'sd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy_rst", {result[62:0], zero, in_ready, out_valid}, 64'b110);
        run64("add_1_1", 4'b0010, 64'd1, 64'd1, 64'd2, 1, 0);

        run8("n8_mul_wrap", 4'b1000, 8'd16, 8'd16, 8'd0, 9);
        run8("n8_mul_ff", 4'b1000, 8'd255, 8'd255, 8'd1, 9);
        run8("n8_udiv", 4'b1001, 8'd200, 8'd7, 8'd28, 9);
        run8("n8_urem", 4'b1010, 8'd200, 8'd7, 8'd4, 9);
        run8("n8_udiv0", 4'b1001, 8'd9, 8'd0, 8'd255, 9);
        run8("n8_add", 4'b0010, 8'd200, 8'd100, 8'd44, 1);
        run8("n8_sub", 4'b0110, 8'd3, 8'd5, 8'd254, 1);

        // Random traffic: the reference model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 1) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            ALUControl = ops[$urandom_range(0, 9)];
            a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = 64'($urandom);
                default: b = {$urandom, $urandom};
            endcase
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
